// File: rtl/mul_16_pkg.sv
// mul_16_pkg
//   Shared types and constants for the sequential shift-and-add multiplier.
//   The numeric values come from mul_16_defs.v so that code still using the
//   `define names stays bit-compatible with the typed enum below.
`timescale 1ns/1ps

`include "mul_16_defs.v"

package mul_16_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    st_idle = `MUL16_IDLE,
    st_run  = `MUL16_RUN,
    st_done = `MUL16_DONE
  } state_t;

  // Iteration bookkeeping: ITERS updates, counter runs 0..LAST_ITER.
  localparam int ITERS     = `MUL16_ITERS;
  localparam int LAST_ITER = `MUL16_LAST;

endpackage

// File: rtl/add_16.sv
// add_16
//   Combinational ripple-carry adder. The carry out of the top bit is not
//   produced: the sum wraps modulo 2^WIDTH.
//
//   Ports:
//     x    in  WIDTH  first addend
//     y    in  WIDTH  second addend
//     sum  out WIDTH  (x + y) mod 2^WIDTH
`timescale 1ns/1ps

module add_16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);

  // carry[i] is the carry into bit i; the carry out of the MSB is never
  // built because nothing downstream uses it.
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum[gi] = x[gi] ^ y[gi] ^ carry[gi];
      if (gi < WIDTH - 1) begin : g_carry
        assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
      end
    end
  endgenerate

endmodule

// File: rtl/mul_16_defs.v
`ifndef MUL_16_DEFS_V
`define MUL_16_DEFS_V

// Shared constants for mul_16 and anything that decodes its state.
// State encodings (2-bit binary).
`define MUL16_IDLE  2'd0
`define MUL16_RUN   2'd1
`define MUL16_DONE  2'd2

// Number of shift-and-add iterations, and the counter value of the last one.
`define MUL16_ITERS 16
`define MUL16_LAST  15

`endif

// File: rtl/mul_16.sv
// mul_16
//   Sequential unsigned shift-and-add multiplier returning the low WIDTH bits
//   of a*b. One add_16 accumulates a gated, left-shifting multiplicand over a
//   fixed 16 iterations; latency from accepted start to done is 17 cycles.
//
//   Ports:
//     clk      in   1      rising-edge clock
//     reset    in   1      asynchronous active-high reset
//     start    in   1      request, only looked at while idle
//     a        in   WIDTH  multiplicand, captured on accepted start
//     b        in   WIDTH  multiplier, captured on accepted start
//     busy     out  1      high while iterating
//     done     out  1      one-cycle pulse, product valid from this cycle
//     product  out  WIDTH  low bits of a*b, held until the next result
`timescale 1ns/1ps

module mul_16
  import mul_16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  // The counter must be able to hold the last iteration index, and the
  // iteration count is tied to the operand width.
  generate
    if ((ITERS != WIDTH) || ((1 << CNT_W) <= ITERS)) begin : g_bad_cfg
      $error("mul_16: WIDTH must equal the iteration count and 2^CNT_W must exceed it");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_ITER);

  state_t           state_reg, state_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] product_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             last_iter;

  // ---------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------
  // Only add the shifted multiplicand when the current multiplier bit is set.
  assign addend    = mplier_reg[0] ? mcand_reg : '0;
  assign last_iter = (cnt_reg == LAST_CNT);

  add_16 #(
    .WIDTH (WIDTH)
  ) u_add (
    .x   (acc_reg),
    .y   (addend),
    .sum (sum)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= st_idle;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      st_idle: begin
        if (start) begin
          state_next = st_run;
        end
      end
      st_run: begin
        // No early exit on a zero multiplier: latency is always fixed.
        if (last_iter) begin
          state_next = st_done;
        end
      end
      st_done: begin
        state_next = st_idle;
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------
  // Decoded from the next state and registered below, so busy/done line up
  // with the state they describe and never depend combinationally on inputs.
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    unique case (state_next)
      st_run:  busy_next = 1'b1;
      st_done: done_next = 1'b1;
      default: begin
        busy_next = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      unique case (state_reg)
        st_idle: begin
          if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        st_run: begin
          acc_reg    <= sum;
          // Bits shifted past the MSB cannot affect the low WIDTH product bits.
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          // Publish the final sum on the same edge that enters DONE, so the
          // product is valid alongside the done pulse.
          if (last_iter) begin
            product_reg <= sum;
          end
        end
        default: begin
          // DONE: nothing to update; product is already in place.
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_mul_16.sv
`timescale 1ns/1ps

module tb_mul_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  always #5 clk = ~clk;

  mul_16 #(
    .WIDTH (16),
    .CNT_W (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected products pushed at acceptance, popped on done.
  logic [15:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive a start request in an idle cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ex);
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    sb.push_back(ex);
    #1;
    start = 1'b0;
    // Operands are free to change once accepted.
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // Called #1 after the accepting edge. Follows the operation until done,
  // checking busy length, latency, product stability and the result.
  task automatic collect(input logic [15:0] ia, input logic [15:0] ib);
    int          c;
    int          busy_cnt;
    bit          seen;
    bit          moved;
    logic [15:0] held;
    logic [15:0] ex;
    c        = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    moved    = 1'b0;
    held     = product;
    while (!seen && c <= 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (product !== held) moved = 1'b1;
        @(posedge clk);
        #1;
        c++;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", c, 17);
    check("busy_cycles", busy_cnt, 16);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("product_stable", {31'd0, moved}, 32'd0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      ex = sb.pop_front();
      check("product", {16'd0, product}, {16'd0, ex});
      $display("txn a=%h b=%h product=%h expected=%h latency=%0d", ia, ib, product, ex, c);
    end
  endtask

  // One cycle after done: pulse must be over and the product held.
  task automatic post_check(input logic [15:0] ex);
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("product_hold", {16'd0, product}, {16'd0, ex});
  endtask

  initial begin
    int dones;

    vecs[0] = '{a: 16'h0003, b: 16'h0005, exp: 16'h000F};
    vecs[1] = '{a: 16'h00FF, b: 16'h0101, exp: 16'hFFFF};
    vecs[2] = '{a: 16'h1234, b: 16'h0010, exp: 16'h2340};
    vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, exp: 16'h0001};
    vecs[4] = '{a: 16'h0000, b: 16'hBEEF, exp: 16'h0000};
    vecs[5] = '{a: 16'h8001, b: 16'h0003, exp: 16'h8003};
    vecs[6] = '{a: 16'hABCD, b: 16'h0001, exp: 16'hABCD};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].exp);
      collect(vecs[i].a, vecs[i].b);
      post_check(vecs[i].exp);
    end

    // Start held high: accepted only from IDLE, one done per 18 cycles.
    @(negedge clk);
    start = 1'b1;
    a     = 16'd7;
    b     = 16'd6;
    @(posedge clk);
    sb.push_back(16'h002A);
    #1;
    collect(16'd7, 16'd6);
    @(posedge clk);
    #1;
    check("held_idle_busy", {31'd0, busy}, 32'd0);
    check("held_idle_done", {31'd0, done}, 32'd0);
    check("held_idle_product", {16'd0, product}, 32'h002A);
    sb.push_back(16'h002A);
    @(posedge clk);
    #1;
    start = 1'b0;
    collect(16'd7, 16'd6);
    post_check(16'h002A);

    // Reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrun_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_done", {31'd0, done}, 32'd0);
    check("async_reset_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("no_spurious_done", dones, 0);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    issue(16'd3, 16'd5, 16'h000F);
    collect(16'd3, 16'd5);
    post_check(16'h000F);

    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_16.md
Name: mul_16

Overview:
- Sequential 16-bit unsigned shift-and-add multiplier.
- Sits directly downstream of add_16: each iteration feeds the accumulator and a gated, shifted multiplicand into one add_16 instance and registers its sum.
- Produces the low 16 bits of a*b (two's-complement wrap, matching add_16's discarded carry) after a fixed 16-cycle iteration.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width; the block is only verified at 16.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  16  multiplicand, captured on accepted start
- b  input  16  multiplier, captured on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; product valid from this cycle
- product  output  16  low 16 bits of a*b; held until the next accepted start

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, product=0, accumulator=0, counter=0. All other internal registers are cleared.
- States: IDLE, RUN, DONE. Encoding is 2 bits, binary.
- IDLE -> RUN when start=1 at a rising edge (cycle N):
  - mcand<=a, mplier<=b, acc<=0, cnt<=0.
  - busy goes high from cycle N+1.
- RUN, each cycle:
  - addend = mplier[0] ? mcand : 0.
  - acc <= add_16(acc, addend). The carry out is dropped.
  - mcand <= mcand << 1, with zero fill. Bits shifted past bit 15 are lost.
  - mplier <= mplier >> 1, with zero fill.
  - cnt <= cnt+1.
  - When cnt==15, the update is the last one; the next state is DONE.
- RUN lasts exactly 16 cycles (N+1..N+16). There is no early exit on mplier==0; latency is fixed.
- DONE (cycle N+17): done=1, busy=0, product=acc. The next state is always IDLE.
- start=1 during RUN or DONE is ignored and has no side effects. a and b may change freely after acceptance.
- Start→done latency is 17 cycles. A back-to-back start is earliest at N+18 (first IDLE cycle).
- product is updated only on entry to DONE. It is stable in IDLE and RUN.
- Reset mid-operation (any state): immediate return to IDLE with all outputs 0. There is no pending result and no spurious done.
- Arithmetic is unsigned modulo 2^16. Signed operands give the correct low 16 bits of the two's-complement product.
- Outputs come straight from registers; there is no combinational path from start/a/b to the outputs.

Decomposition:
- Shared include file mul_16_defs.v: `define constants for the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the iteration count (16) and the last-iteration value (15).
- Sub-module: one add_16 instance for the accumulate step. No other sub-modules are needed.
- Registers (acc, mcand, mplier, cnt, state, product, done) live in mul_16 with async-reset always blocks.

Test Plan:
- Reset, then a=3, b=5, start pulse -> busy high for 16 cycles, done one-cycle at start+17, product=16'h000F.
- a=16'h00FF, b=16'h0101 -> product=16'hFFFF. Then a=16'h1234, b=16'h0010 -> product=16'h2340 (wrap drops 0x1_0000).
- a=16'hFFFF, b=16'hFFFF -> product=16'h0001. Then a=0, b=16'hBEEF -> product=0, with latency still 17.
- Hold start=1 continuously with a=7, b=6 -> first done gives 16'h002A. Re-entry to RUN happens only from IDLE, with exactly one done per 18 cycles. Changing a/b during RUN does not alter the result.
- Assert reset at RUN cycle 8 -> busy=0, done=0, product=0 immediately (asynchronously). After release, no done appears until a new start, and a fresh 3*5 returns 16'h000F.
